// File: rtl/charmap_blit.sv
//==============================================================================
// Module : charmap_blit
// Fill/scroll block engine sharing the character-map RAM port with CPU writes.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

module charmap_blit #(
    parameter int COLS = 40,
    parameter int ROWS = 30
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [7:0]  cmd_char,
    input  logic [7:0]  cmd_fg,
    input  logic [7:0]  cmd_bg,
    output logic        busy,
    output logic        done,
    input  logic        cpu_wr,
    input  logic [2:0]  cpu_sel,
    input  logic [11:0] cpu_addr,
    input  logic [7:0]  cpu_data,
    output logic [11:0] ram_addr,
    output logic [2:0]  ram_we,
    output logic [7:0]  ram_wdata_ch,
    output logic [7:0]  ram_wdata_fg,
    output logic [7:0]  ram_wdata_bg,
    input  logic [7:0]  ram_rdata_ch,
    input  logic [7:0]  ram_rdata_fg,
    input  logic [7:0]  ram_rdata_bg
);

    localparam logic [5:0] c_LAST_COL = 6'(COLS - 1);
    localparam logic [5:0] c_LAST_ROW = 6'(ROWS - 1);
    localparam logic [5:0] c_COPY_UP  = 6'(ROWS - 2);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        WR   = 3'd2,
        FILL = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t      state_q;
    logic        busy_q;
    logic        done_q;
    logic        down_q;
    logic        cap_q;
    logic [5:0]  row_q;
    logic [5:0]  col_q;
    logic [7:0]  fch_q, ffg_q, fbg_q;
    logic [7:0]  hch_q, hfg_q, hbg_q;

    logic        w_last_col;
    logic [5:0]  w_row_next;
    logic [5:0]  w_src_row;
    logic [5:0]  w_copy_last;
    logic [5:0]  w_fill_last;

    assign w_last_col  = (col_q == c_LAST_COL);
    assign w_row_next  = down_q ? (row_q - 6'd1) : (row_q + 6'd1);
    assign w_src_row   = w_row_next;
    assign w_copy_last = down_q ? 6'd1 : c_COPY_UP;
    assign w_fill_last = down_q ? 6'd0 : c_LAST_ROW;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            down_q  <= 1'b0;
            cap_q   <= 1'b0;
            row_q   <= 6'd0;
            col_q   <= 6'd0;
            fch_q   <= 8'd0;
            ffg_q   <= 8'd0;
            fbg_q   <= 8'd0;
            hch_q   <= 8'd0;
            hfg_q   <= 8'd0;
            hbg_q   <= 8'd0;
        end else begin
            // Read data is valid the cycle after RD; grab it even if that cycle is stolen.
            cap_q <= 1'b0;
            if (cap_q) begin
                hch_q <= ram_rdata_ch;
                hfg_q <= ram_rdata_fg;
                hbg_q <= ram_rdata_bg;
            end
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        fch_q  <= cmd_char;
                        ffg_q  <= cmd_fg;
                        fbg_q  <= cmd_bg;
                        col_q  <= 6'd0;
                        busy_q <= 1'b1;
                        case (cmd_op)
                            2'd0: begin
                                down_q  <= 1'b0;
                                row_q   <= 6'd0;
                                state_q <= FILL;
                            end
                            2'd1: begin
                                down_q  <= 1'b0;
                                row_q   <= 6'd0;
                                state_q <= RD;
                            end
                            2'd2: begin
                                down_q  <= 1'b1;
                                row_q   <= c_LAST_ROW;
                                state_q <= RD;
                            end
                            default: begin
                                state_q <= DONE;
                                done_q  <= 1'b1;
                            end
                        endcase
                    end
                end
                RD: begin
                    if (!cpu_wr) begin
                        cap_q   <= 1'b1;
                        state_q <= WR;
                    end
                end
                WR: begin
                    if (!cpu_wr) begin
                        col_q <= w_last_col ? 6'd0 : (col_q + 6'd1);
                        if (w_last_col) begin
                            row_q <= w_row_next;
                        end
                        state_q <= (w_last_col && (row_q == w_copy_last)) ? FILL : RD;
                    end
                end
                FILL: begin
                    if (!cpu_wr) begin
                        col_q <= w_last_col ? 6'd0 : (col_q + 6'd1);
                        if (w_last_col) begin
                            row_q <= w_row_next;
                        end
                        if (w_last_col && (row_q == w_fill_last)) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    logic [11:0] w_eng_addr;
    logic [2:0]  w_eng_we;
    logic [7:0]  w_eng_ch, w_eng_fg, w_eng_bg;

    always_comb begin
        w_eng_addr = {row_q, col_q};
        w_eng_we   = 3'b000;
        w_eng_ch   = fch_q;
        w_eng_fg   = ffg_q;
        w_eng_bg   = fbg_q;
        case (state_q)
            RD: w_eng_addr = {w_src_row, col_q};
            WR: begin
                w_eng_we = 3'b111;
                // First WR cycle writes the live read data straight through.
                w_eng_ch = cap_q ? ram_rdata_ch : hch_q;
                w_eng_fg = cap_q ? ram_rdata_fg : hfg_q;
                w_eng_bg = cap_q ? ram_rdata_bg : hbg_q;
            end
            FILL:    w_eng_we = 3'b111;
            default: w_eng_we = 3'b000;
        endcase
        if (reset) begin
            w_eng_we = 3'b000;
        end
    end

    always_comb begin
        if (cpu_wr) begin
            ram_addr     = cpu_addr;
            ram_we       = cpu_sel;
            ram_wdata_ch = cpu_data;
            ram_wdata_fg = cpu_data;
            ram_wdata_bg = cpu_data;
        end else begin
            ram_addr     = w_eng_addr;
            ram_we       = w_eng_we;
            ram_wdata_ch = w_eng_ch;
            ram_wdata_fg = w_eng_fg;
            ram_wdata_bg = w_eng_bg;
        end
    end

    assign cmd_ready = (state_q == IDLE) && !reset;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

`default_nettype wire

// File: tb/tb_charmap_blit.sv
//==============================================================================
// Module : tb_charmap_blit
// Directed bench for charmap_blit with a synchronous RAM model and scoreboard.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_charmap_blit;

    localparam int COLS     = 40;
    localparam int ROWS     = 30;
    localparam int FILL_LAT = ROWS * COLS + 1;
    localparam int SCR_LAT  = 2 * (ROWS - 1) * COLS + COLS + 1;
    localparam int N_COPY   = (ROWS - 1) * COLS;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'd3;
    logic [7:0]  cmd_char = 8'd0, cmd_fg = 8'd0, cmd_bg = 8'd0;
    logic        busy, done;
    logic        cpu_wr = 1'b0;
    logic [2:0]  cpu_sel = 3'b000;
    logic [11:0] cpu_addr = 12'd0;
    logic [7:0]  cpu_data = 8'd0;
    logic [11:0] ram_addr;
    logic [2:0]  ram_we;
    logic [7:0]  ram_wdata_ch, ram_wdata_fg, ram_wdata_bg;
    logic [7:0]  ram_rdata_ch = 8'd0, ram_rdata_fg = 8'd0, ram_rdata_bg = 8'd0;

    charmap_blit #(.COLS(COLS), .ROWS(ROWS)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_char(cmd_char), .cmd_fg(cmd_fg), .cmd_bg(cmd_bg),
        .busy(busy), .done(done),
        .cpu_wr(cpu_wr), .cpu_sel(cpu_sel), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
        .ram_addr(ram_addr), .ram_we(ram_we),
        .ram_wdata_ch(ram_wdata_ch), .ram_wdata_fg(ram_wdata_fg), .ram_wdata_bg(ram_wdata_bg),
        .ram_rdata_ch(ram_rdata_ch), .ram_rdata_fg(ram_rdata_fg), .ram_rdata_bg(ram_rdata_bg)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] pat_ch(input int a);
        logic [11:0] v = 12'(a);
        return v[7:0];
    endfunction
    function automatic logic [7:0] pat_fg(input int a);
        logic [11:0] v = 12'(a);
        return v[7:0] ^ 8'h5A;
    endfunction
    function automatic logic [7:0] pat_bg(input int a);
        logic [11:0] v = 12'(a);
        return v[11:4];
    endfunction

    // Planes plus engine-write monitor
    logic [7:0] mem_ch [4096];
    logic [7:0] mem_fg [4096];
    logic [7:0] mem_bg [4096];
    logic       init_req = 1'b1;
    int         eng_wr = 0;
    int         bad_wr = 0;

    always @(posedge clk) begin
        if (init_req) begin
            for (int i = 0; i < 4096; i++) begin
                mem_ch[i] <= pat_ch(i);
                mem_fg[i] <= pat_fg(i);
                mem_bg[i] <= pat_bg(i);
            end
        end else begin
            if (ram_we[0]) mem_ch[ram_addr] <= ram_wdata_ch;
            if (ram_we[1]) mem_fg[ram_addr] <= ram_wdata_fg;
            if (ram_we[2]) mem_bg[ram_addr] <= ram_wdata_bg;
        end
        ram_rdata_ch <= mem_ch[ram_addr];
        ram_rdata_fg <= mem_fg[ram_addr];
        ram_rdata_bg <= mem_bg[ram_addr];
        if (ram_we != 3'b000 && !cpu_wr) begin
            eng_wr <= eng_wr + 1;
            if (int'(ram_addr[5:0]) >= COLS || int'(ram_addr[11:6]) >= ROWS)
                bad_wr <= bad_wr + 1;
        end
    end

    logic [7:0] ref_ch [4096];
    logic [7:0] ref_fg [4096];
    logic [7:0] ref_bg [4096];
    int         exp_q[$];
    int         n_assert = 0;
    int         n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic ref_reset();
        for (int i = 0; i < 4096; i++) begin
            ref_ch[i] = pat_ch(i);
            ref_fg[i] = pat_fg(i);
            ref_bg[i] = pat_bg(i);
        end
    endtask

    task automatic init_mem();
        init_req = 1'b1;
        @(posedge clk); #1;
        init_req = 1'b0;
        ref_reset();
    endtask

    task automatic ref_fill_row(input int r, input logic [7:0] ch, input logic [7:0] fg,
                                input logic [7:0] bg);
        for (int c = 0; c < COLS; c++) begin
            ref_ch[r*64+c] = ch;
            ref_fg[r*64+c] = fg;
            ref_bg[r*64+c] = bg;
        end
    endtask

    task automatic ref_copy_row(input int dst, input int src);
        for (int c = 0; c < COLS; c++) begin
            ref_ch[dst*64+c] = ref_ch[src*64+c];
            ref_fg[dst*64+c] = ref_fg[src*64+c];
            ref_bg[dst*64+c] = ref_bg[src*64+c];
        end
    endtask

    task automatic ref_apply(input logic [1:0] op, input logic [7:0] ch, input logic [7:0] fg,
                             input logic [7:0] bg);
        if (op == 2'd0) begin
            for (int r = 0; r < ROWS; r++) ref_fill_row(r, ch, fg, bg);
        end else if (op == 2'd1) begin
            for (int r = 0; r < ROWS - 1; r++) ref_copy_row(r, r + 1);
            ref_fill_row(ROWS - 1, ch, fg, bg);
        end else if (op == 2'd2) begin
            for (int r = ROWS - 1; r >= 1; r--) ref_copy_row(r, r - 1);
            ref_fill_row(0, ch, fg, bg);
        end
    endtask

    task automatic check_mem(input string tag);
        for (int i = 0; i < 4096; i++)
            chk(tag, {8'd0, mem_ch[i], mem_fg[i], mem_bg[i]},
                {8'd0, ref_ch[i], ref_fg[i], ref_bg[i]});
    endtask

    task automatic start_cmd(input logic [1:0] op, input logic [7:0] ch, input logic [7:0] fg,
                             input logic [7:0] bg, input int exp_lat);
        int w = 0;
        while (!cmd_ready && w < 100) begin
            @(posedge clk); #1;
            w++;
        end
        chk("ready_before_cmd", {31'd0, cmd_ready}, 1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_char  = ch;
        cmd_fg    = fg;
        cmd_bg    = bg;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        exp_q.push_back(exp_lat);
        chk("busy_after_accept", {31'd0, busy}, 1);
        chk("ready_low_when_busy", {31'd0, cmd_ready}, 0);
    endtask

    task automatic wait_done(input bit steal, output int nsteal);
        int  k = 1;
        int  ns = 0;
        bit  seen = 1'b0;
        bit  pend = 1'b0;
        int  lat;
        logic [11:0] a;
        while (k <= 10000) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            // A command offered mid-operation must be dropped, not queued.
            if (k == 5) begin
                cmd_valid = 1'b1;
                cmd_op    = 2'd0;
            end else begin
                cmd_valid = 1'b0;
            end
            if (steal) begin
                if (pend) begin
                    pend     = 1'b0;
                    a        = {6'(ns % 64), 6'd63};
                    cpu_wr   = 1'b1;
                    cpu_addr = a;
                    cpu_sel  = 3'b001 << (ns % 3);
                    cpu_data = 8'(ns);
                    if (cpu_sel[0]) ref_ch[a] = cpu_data;
                    if (cpu_sel[1]) ref_fg[a] = cpu_data;
                    if (cpu_sel[2]) ref_bg[a] = cpu_data;
                    ns++;
                end else if (cpu_wr) begin
                    cpu_wr = 1'b0;
                end else if (busy && !done && ram_we == 3'b000) begin
                    pend = 1'b1;
                end
            end
            @(posedge clk); #1;
            k++;
        end
        cpu_wr    = 1'b0;
        cmd_valid = 1'b0;
        nsteal    = ns;
        chk("done_seen", {31'd0, seen}, 1);
        if (seen && exp_q.size() > 0) begin
            lat = exp_q.pop_front();
            chk("latency", k, lat);
        end
        @(posedge clk); #1;
        chk("done_one_cycle", {31'd0, done}, 0);
        chk("busy_clear", {31'd0, busy}, 0);
        chk("ready_after_done", {31'd0, cmd_ready}, 1);
        @(posedge clk); #1;
        chk("no_queued_cmd", {31'd0, busy}, 0);
    endtask

    int ns_dummy;
    int wr0;

    initial begin
        ref_reset();
        @(posedge clk); #1;
        init_req = 1'b0;
        chk("rst_ready", {31'd0, cmd_ready}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_we", {29'd0, ram_we}, 0);

        // CPU pass-through while reset is held
        cpu_wr = 1'b1; cpu_sel = 3'b010; cpu_addr = 12'hFC0; cpu_data = 8'hA5;
        #1;
        chk("pass_we", {29'd0, ram_we}, 32'h2);
        chk("pass_addr", {20'd0, ram_addr}, 32'hFC0);
        chk("pass_wd_fg", {24'd0, ram_wdata_fg}, 32'hA5);
        chk("pass_wd_bg", {24'd0, ram_wdata_bg}, 32'hA5);
        @(posedge clk); #1;
        cpu_wr = 1'b0;
        ref_fg[12'hFC0] = 8'hA5;
        reset = 1'b0;
        #1;
        chk("ready_after_rst", {31'd0, cmd_ready}, 1);

        // Full fill
        wr0 = eng_wr;
        ref_apply(2'd0, 8'h20, 8'h07, 8'h00);
        start_cmd(2'd0, 8'h20, 8'h07, 8'h00, FILL_LAT);
        wait_done(1'b0, ns_dummy);
        chk("fill_wr_count", eng_wr - wr0, ROWS * COLS);
        check_mem("fill_mem");

        // Scroll up
        init_mem();
        wr0 = eng_wr;
        ref_apply(2'd1, 8'h11, 8'h22, 8'h33);
        start_cmd(2'd1, 8'h11, 8'h22, 8'h33, SCR_LAT);
        wait_done(1'b0, ns_dummy);
        chk("up_wr_count", eng_wr - wr0, N_COPY + COLS);
        check_mem("up_mem");

        // Scroll down
        init_mem();
        ref_apply(2'd2, 8'h44, 8'h55, 8'h66);
        start_cmd(2'd2, 8'h44, 8'h55, 8'h66, SCR_LAT);
        wait_done(1'b0, ns_dummy);
        check_mem("down_mem");

        // Scroll up with the cycle after every read stolen by the CPU
        init_mem();
        ref_apply(2'd1, 8'h77, 8'h88, 8'h99);
        start_cmd(2'd1, 8'h77, 8'h88, 8'h99, SCR_LAT + N_COPY);
        wait_done(1'b1, ns_dummy);
        chk("steal_count", ns_dummy, N_COPY);
        check_mem("steal_mem");

        // No-op
        wr0 = eng_wr;
        start_cmd(2'd3, 8'hEE, 8'hEE, 8'hEE, 1);
        wait_done(1'b0, ns_dummy);
        chk("noop_wr_count", eng_wr - wr0, 0);

        // Reset in the middle of a scroll, then a clean fill
        init_mem();
        start_cmd(2'd1, 8'h01, 8'h02, 8'h03, SCR_LAT);
        repeat (1000) @(posedge clk);
        #1;
        chk("mid_busy", {31'd0, busy}, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("abort_busy", {31'd0, busy}, 0);
        chk("abort_done", {31'd0, done}, 0);
        chk("abort_we", {29'd0, ram_we}, 0);
        chk("abort_ready", {31'd0, cmd_ready}, 0);
        reset = 1'b0;
        #1;
        chk("abort_ready_rel", {31'd0, cmd_ready}, 1);
        exp_q.delete();
        ref_apply(2'd0, 8'hC3, 8'h3C, 8'h5A);
        start_cmd(2'd0, 8'hC3, 8'h3C, 8'h5A, FILL_LAT);
        wait_done(1'b0, ns_dummy);
        check_mem("refill_mem");
        chk("no_offscreen_wr", bad_wr, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
